// File: rtl/mjpg_pkg.sv
// Shared constants for the MJPEG frame FIFO.
// Marker bytes and write-side FSM encoding.
package mjpg_pkg;

  localparam logic [7:0] MRK_FF  = 8'hFF;
  localparam logic [7:0] MRK_SOI = 8'hD8;
  localparam logic [7:0] MRK_EOI = 8'hD9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DROP
  } wr_st_e;

endpackage

// File: rtl/jpeg_frame_ram.sv
// Simple dual-port frame RAM, 2^ADDR_W x 9 bits {last, data}.
// One write port, one registered read port.
module jpeg_frame_ram #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [8:0]        wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [8:0]        rdata_o
);

  logic [8:0] mem_q [0:(1<<ADDR_W)-1];
  logic [8:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i)
      mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (re_i)
      rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mjpg_frame_fifo.sv
// Store-and-forward JPEG frame buffer: extracts SOI..EOI frames,
// drops frames that do not fit, and streams committed frames out.
module mjpg_frame_fifo #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jvalid,
  input  logic [7:0]        jpeg,
  output logic              m_valid,
  output logic [7:0]        m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [ADDR_W-1:0] last_len
);

  import mjpg_pkg::*;

  localparam logic [ADDR_W-1:0] P1 = ADDR_W'(1);

  wr_st_e            st_q;
  wr_st_e            st_d;
  logic              prev_ff_q;
  logic [7:0]        stg_q;
  logic              stg_vld_q;
  logic              stg_eoi_q;
  logic [ADDR_W-1:0] wr_q;
  logic [ADDR_W-1:0] wr_d;
  logic [ADDR_W-1:0] commit_q;
  logic [ADDR_W-1:0] commit_d;
  logic [ADDR_W-1:0] rd_q;
  logic [CNT_W-1:0]  fc_q;
  logic [CNT_W-1:0]  dc_q;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] len_d;
  logic              fc_inc;
  logic              dc_inc;

  logic              soi_in;
  logic              eoi_in;
  logic              full_wr;
  logic              full_soi;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [8:0]        wdata;
  logic              rd_en;
  logic [8:0]        ram_q;

  logic              pf_vld_q;
  logic              out_vld_q;
  logic [7:0]        out_data_q;
  logic              out_last_q;
  logic              pop;
  logic              out_ld;

  assign soi_in   = jvalid & prev_ff_q & (jpeg == MRK_SOI);
  assign eoi_in   = jvalid & prev_ff_q & (jpeg == MRK_EOI);
  assign full_wr  = (wr_q + P1) == rd_q;
  assign full_soi = (commit_q + P1) == rd_q;

  // A new SOI outranks the staged byte, which is then always the FF
  // that belongs to the new frame and is written explicitly.
  always_comb begin
    st_d     = st_q;
    wr_d     = wr_q;
    commit_d = commit_q;
    len_d    = len_q;
    fc_inc   = 1'b0;
    dc_inc   = 1'b0;
    we       = 1'b0;
    waddr    = wr_q;
    wdata    = {stg_eoi_q, stg_q};
    if (soi_in) begin
      dc_inc = (st_q != ST_IDLE);
      wr_d   = commit_q;
      if (full_soi) begin
        st_d = ST_DROP;
      end else begin
        we    = 1'b1;
        waddr = commit_q;
        wdata = {1'b0, MRK_FF};
        wr_d  = commit_q + P1;
        st_d  = ST_FILL;
      end
    end else if (stg_vld_q) begin
      unique case (st_q)
        ST_FILL: begin
          if (full_wr) begin
            if (stg_eoi_q) begin
              wr_d   = commit_q;
              dc_inc = 1'b1;
              st_d   = ST_IDLE;
            end else begin
              st_d = ST_DROP;
            end
          end else begin
            we   = 1'b1;
            wr_d = wr_q + P1;
            if (stg_eoi_q) begin
              commit_d = wr_q + P1;
              len_d    = wr_q - commit_q + P1;
              fc_inc   = 1'b1;
              st_d     = ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          if (stg_eoi_q) begin
            wr_d   = commit_q;
            dc_inc = 1'b1;
            st_d   = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  // Reading against commit_d lets the first byte launch in the commit cycle.
  assign pop    = out_vld_q & m_ready;
  assign out_ld = ~out_vld_q | pop;
  assign rd_en  = ~rst & (rd_q != commit_d) & (~pf_vld_q | out_ld);

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= ST_IDLE;
      prev_ff_q  <= 1'b0;
      stg_q      <= '0;
      stg_vld_q  <= 1'b0;
      stg_eoi_q  <= 1'b0;
      wr_q       <= '0;
      commit_q   <= '0;
      rd_q       <= '0;
      fc_q       <= '0;
      dc_q       <= '0;
      len_q      <= '0;
      pf_vld_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      st_q      <= st_d;
      wr_q      <= wr_d;
      commit_q  <= commit_d;
      len_q     <= len_d;
      fc_q      <= fc_q + CNT_W'(fc_inc);
      dc_q      <= dc_q + CNT_W'(dc_inc);
      stg_vld_q <= jvalid;
      if (jvalid) begin
        prev_ff_q <= (jpeg == MRK_FF);
        stg_q     <= jpeg;
        stg_eoi_q <= eoi_in;
      end
      rd_q     <= rd_q + ADDR_W'(rd_en);
      pf_vld_q <= rd_en | (pf_vld_q & ~out_ld);
      if (out_ld) begin
        out_vld_q <= pf_vld_q;
        if (pf_vld_q) begin
          out_data_q <= ram_q[7:0];
          out_last_q <= ram_q[8];
        end
      end
    end
  end

  jpeg_frame_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i (wdata),
    .re_i    (rd_en),
    .raddr_i (rd_q),
    .rdata_o (ram_q)
  );

  assign m_valid   = out_vld_q;
  assign m_data    = out_data_q;
  assign m_last    = out_last_q;
  assign frame_cnt = fc_q;
  assign drop_cnt  = dc_q;
  assign last_len  = len_q;

endmodule

// File: tb/tb_mjpg_frame_fifo.sv
// Directed bench for mjpg_frame_fifo with a 16-byte buffer.
// Expected streams and counters are hand-derived per scenario.
module tb_mjpg_frame_fifo;

  localparam int AW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          jvalid;
  logic [7:0]    jpeg;
  logic          m_valid;
  logic [7:0]    m_data;
  logic          m_last;
  logic          m_ready;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] last_len;

  int nvec = 0;
  int nerr = 0;

  logic [8:0] outq[$];
  logic [7:0] stim[$];
  logic [8:0] expq[$];

  int         stab_err = 0;
  logic       hold = 1'b0;
  logic [7:0] hold_d = '0;
  logic       hold_l = 1'b0;

  always #5 clk = ~clk;

  mjpg_frame_fifo #(
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .jvalid    (jvalid),
    .jpeg      (jpeg),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt),
    .last_len  (last_len)
  );

  always @(negedge clk) begin
    if (rst) begin
      hold <= 1'b0;
    end else begin
      if (hold && (!m_valid || m_data !== hold_d || m_last !== hold_l))
        stab_err <= stab_err + 1;
      if (m_valid && m_ready)
        outq.push_back({m_last, m_data});
      hold   <= m_valid && !m_ready;
      hold_d <= m_data;
      hold_l <= m_last;
    end
  end

  task automatic cyc(input logic v, input logic [7:0] b);
    jvalid = v;
    jpeg   = b;
    @(posedge clk);
    #1;
    jvalid = 1'b0;
  endtask

  task automatic feed(input int gap, input bit rnd);
    foreach (stim[i]) begin
      if (rnd) m_ready = 1'($urandom_range(0, 1));
      cyc(1'b1, stim[i]);
      for (int g = 0; g < gap; g++) begin
        if (rnd) m_ready = 1'($urandom_range(0, 1));
        cyc(1'b0, 8'h00);
      end
    end
  endtask

  task automatic drain(input int n, input bit rnd, output bit ok);
    int t;
    t = 0;
    while (outq.size() < n && t < 300) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc(1'b0, 8'h00);
      t++;
    end
    ok = (outq.size() >= n);
    m_ready = 1'b1;
    repeat (6) cyc(1'b0, 8'h00);
  endtask

  task automatic build_exp();
    expq.delete();
    foreach (stim[i])
      expq.push_back({(i == stim.size() - 1), stim[i]});
  endtask

  task automatic test_reset();
    rst = 1'b1; jvalid = 1'b0; jpeg = '0; m_ready = 1'b0;
    @(posedge clk); #1;
    repeat (3) cyc(1'b0, 8'h00);
    nvec++;
    if (m_valid !== 1'b0) begin
      nerr++; $display("FAIL rst_m_valid got %b want 0", m_valid);
    end
    nvec++;
    if (m_data !== 8'h00) begin
      nerr++; $display("FAIL rst_m_data got %h want 00", m_data);
    end
    nvec++;
    if (m_last !== 1'b0) begin
      nerr++; $display("FAIL rst_m_last got %b want 0", m_last);
    end
    nvec++;
    if (frame_cnt !== 16'd0) begin
      nerr++; $display("FAIL rst_frame_cnt got %0d want 0", frame_cnt);
    end
    nvec++;
    if (drop_cnt !== 16'd0) begin
      nerr++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt);
    end
    nvec++;
    if (last_len !== 4'd0) begin
      nerr++; $display("FAIL rst_last_len got %0d want 0", last_len);
    end
    rst = 1'b0;
    repeat (2) cyc(1'b0, 8'h00);
    nvec++;
    if (m_valid !== 1'b0) begin
      nerr++; $display("FAIL idle_m_valid got %b want 0", m_valid);
    end
  endtask

  task automatic test_single();
    bit ok;
    logic [8:0] got;
    outq.delete();
    m_ready = 1'b1;
    stim = '{8'h00, 8'h12, 8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'h00, 8'hBB, 8'hFF, 8'hD9};
    feed(2, 1'b0);
    stim = '{8'hFF, 8'hD8, 8'hAA, 8'hFF, 8'h00, 8'hBB, 8'hFF, 8'hD9};
    build_exp();
    drain(8, 1'b0, ok);
    nvec++;
    if (!ok || outq.size() != 8) begin
      nerr++; $display("FAIL single_count got %0d want 8", outq.size());
    end
    foreach (expq[i]) begin
      got = 'x;
      if (i < outq.size()) got = outq[i];
      nvec++;
      if (got !== expq[i]) begin
        nerr++; $display("FAIL single_byte%0d got %h want %h", i, got, expq[i]);
      end
    end
    nvec++;
    if (frame_cnt !== 16'd1) begin
      nerr++; $display("FAIL single_frame_cnt got %0d want 1", frame_cnt);
    end
    nvec++;
    if (last_len !== 4'd8) begin
      nerr++; $display("FAIL single_last_len got %0d want 8", last_len);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [8:0] got;
    outq.delete();
    stim = '{8'hFF, 8'hD8, 8'h01, 8'hFF, 8'h00, 8'h02, 8'hFF, 8'hD9};
    build_exp();
    feed(0, 1'b1);
    stim = '{8'hFF, 8'hD8, 8'h03, 8'h04, 8'hFF, 8'hD9};
    foreach (stim[i])
      expq.push_back({(i == stim.size() - 1), stim[i]});
    feed(0, 1'b1);
    drain(14, 1'b1, ok);
    nvec++;
    if (!ok || outq.size() != 14) begin
      nerr++; $display("FAIL b2b_count got %0d want 14", outq.size());
    end
    foreach (expq[i]) begin
      got = 'x;
      if (i < outq.size()) got = outq[i];
      nvec++;
      if (got !== expq[i]) begin
        nerr++; $display("FAIL b2b_byte%0d got %h want %h", i, got, expq[i]);
      end
    end
    nvec++;
    if (stab_err != 0) begin
      nerr++; $display("FAIL b2b_stable got %0d unstable holds want 0", stab_err);
    end
    nvec++;
    if (frame_cnt !== 16'd3) begin
      nerr++; $display("FAIL b2b_frame_cnt got %0d want 3", frame_cnt);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [8:0] got;
    outq.delete();
    m_ready = 1'b1;
    stim.delete();
    stim.push_back(8'hFF);
    stim.push_back(8'hD8);
    for (int k = 0; k < 16; k++) stim.push_back(8'(8'h10 + k));
    stim.push_back(8'hFF);
    stim.push_back(8'hD9);
    feed(1, 1'b0);
    stim = '{8'hFF, 8'hD8, 8'hA1, 8'hA2, 8'hFF, 8'hD9};
    build_exp();
    feed(1, 1'b0);
    drain(6, 1'b0, ok);
    nvec++;
    if (!ok || outq.size() != 6) begin
      nerr++; $display("FAIL ovf_count got %0d want 6", outq.size());
    end
    foreach (expq[i]) begin
      got = 'x;
      if (i < outq.size()) got = outq[i];
      nvec++;
      if (got !== expq[i]) begin
        nerr++; $display("FAIL ovf_byte%0d got %h want %h", i, got, expq[i]);
      end
    end
    nvec++;
    if (drop_cnt !== 16'd1) begin
      nerr++; $display("FAIL ovf_drop_cnt got %0d want 1", drop_cnt);
    end
    nvec++;
    if (frame_cnt !== 16'd4) begin
      nerr++; $display("FAIL ovf_frame_cnt got %0d want 4", frame_cnt);
    end
    nvec++;
    if (last_len !== 4'd6) begin
      nerr++; $display("FAIL ovf_last_len got %0d want 6", last_len);
    end
  endtask

  task automatic test_exact_fit();
    bit ok;
    logic [8:0] got;
    outq.delete();
    m_ready = 1'b0;
    stim.delete();
    stim.push_back(8'hFF);
    stim.push_back(8'hD8);
    for (int k = 0; k < 11; k++) stim.push_back(8'(8'h20 + k));
    stim.push_back(8'hFF);
    stim.push_back(8'hD9);
    build_exp();
    feed(0, 1'b0);
    repeat (2) cyc(1'b0, 8'h00);
    nvec++;
    if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 8'hFF}) begin
      nerr++;
      $display("FAIL fit_latency got v=%b l=%b d=%h want v=1 l=0 d=ff",
               m_valid, m_last, m_data);
    end
    nvec++;
    if (last_len !== 4'd15) begin
      nerr++; $display("FAIL fit_last_len got %0d want 15", last_len);
    end
    nvec++;
    if (frame_cnt !== 16'd5) begin
      nerr++; $display("FAIL fit_frame_cnt got %0d want 5", frame_cnt);
    end
    drain(15, 1'b0, ok);
    nvec++;
    if (!ok || outq.size() != 15) begin
      nerr++; $display("FAIL fit_count got %0d want 15", outq.size());
    end
    foreach (expq[i]) begin
      got = 'x;
      if (i < outq.size()) got = outq[i];
      nvec++;
      if (got !== expq[i]) begin
        nerr++; $display("FAIL fit_byte%0d got %h want %h", i, got, expq[i]);
      end
    end
  endtask

  task automatic test_missing_eoi();
    bit ok;
    logic [8:0] got;
    outq.delete();
    m_ready = 1'b1;
    stim = '{8'hFF, 8'hD8, 8'h11, 8'h22, 8'hFF, 8'hD8, 8'h33, 8'hFF, 8'hD9};
    feed(0, 1'b0);
    stim = '{8'hFF, 8'hD8, 8'h33, 8'hFF, 8'hD9};
    build_exp();
    drain(5, 1'b0, ok);
    nvec++;
    if (!ok || outq.size() != 5) begin
      nerr++; $display("FAIL noeoi_count got %0d want 5", outq.size());
    end
    foreach (expq[i]) begin
      got = 'x;
      if (i < outq.size()) got = outq[i];
      nvec++;
      if (got !== expq[i]) begin
        nerr++; $display("FAIL noeoi_byte%0d got %h want %h", i, got, expq[i]);
      end
    end
    nvec++;
    if (drop_cnt !== 16'd2) begin
      nerr++; $display("FAIL noeoi_drop_cnt got %0d want 2", drop_cnt);
    end
    nvec++;
    if (last_len !== 4'd5) begin
      nerr++; $display("FAIL noeoi_last_len got %0d want 5", last_len);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [8:0] got;
    outq.delete();
    m_ready = 1'b0;
    stim = '{8'hFF, 8'hD8, 8'h55, 8'hFF, 8'hD9, 8'hFF, 8'hD8, 8'h66, 8'h77};
    feed(0, 1'b0);
    rst = 1'b1;
    m_ready = 1'b1;
    cyc(1'b0, 8'h00);
    rst = 1'b0;
    nvec++;
    if (m_valid !== 1'b0) begin
      nerr++; $display("FAIL rmid_m_valid got %b want 0", m_valid);
    end
    nvec++;
    if ({frame_cnt, drop_cnt, last_len} !== '0) begin
      nerr++;
      $display("FAIL rmid_counters got fc=%0d dc=%0d len=%0d want 0 0 0",
               frame_cnt, drop_cnt, last_len);
    end
    outq.delete();
    stim = '{8'hFF, 8'hD8, 8'h99, 8'hFF, 8'hD9};
    build_exp();
    feed(0, 1'b0);
    drain(5, 1'b0, ok);
    nvec++;
    if (!ok || outq.size() != 5) begin
      nerr++; $display("FAIL rmid_count got %0d want 5", outq.size());
    end
    foreach (expq[i]) begin
      got = 'x;
      if (i < outq.size()) got = outq[i];
      nvec++;
      if (got !== expq[i]) begin
        nerr++; $display("FAIL rmid_byte%0d got %h want %h", i, got, expq[i]);
      end
    end
    nvec++;
    if (frame_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      nerr++;
      $display("FAIL rmid_after got fc=%0d dc=%0d want 1 0", frame_cnt, drop_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    jvalid = 1'b0;
    jpeg = '0;
    m_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_exact_fit();
    test_missing_eoi();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
